combiner_regs_bank: RTL

- Parametrised, multi-channel successor to the digital combiner register file.
- Holds NUM_CH independent sets of combiner coefficients: lag, lead, sweep rate, sweep limit/options and reference level.
- Double-buffers the sets so that new coefficients reach the loop atomically, on a commit write or a frame-aligned update strobe.
- Adds synchronised lock status, sticky lock-loss flags with clear-on-read, and a registered read path. Sits between the processor bus decoder and the NUM_CH combiner datapaths.

---
 rtl/combiner_regs_bank.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/combiner_regs_bank.sv
// ---------------------------------------------------------------------------
// combiner_regs_bank
//
// Multi-channel combiner coefficient register bank. Holds NUM_CH sets of
// lag / lead / sweep rate / sweep limit+options / reference level
// coefficients, a synchronised lock status with sticky loss flags, and a
// registered read path towards the processor bus.
//
// Build option: COMB_SHADOW_EN
//   defined   - bus writes land in shadow registers; a COMMIT write or
//               updateStrobe copies pending shadow sets to the active
//               outputs atomically, and commitDone pulses afterwards.
//   undefined - no shadow stage; writes reach the active outputs on the
//               write edge, COMMIT/updateStrobe are ignored, commitDone = 0.
//
// Ports
//   busClk        bus/register clock (only clock)
//   reset         asynchronous active-high reset
//   cs, rd        block select, read strobe
//   wr0..wr3      byte write enables for dataIn[7:0] .. dataIn[31:24]
//   addr          [4+CH_W:5] channel, [4:2] word, [1:0] ignored
//   dataIn        write data
//   dataOut       registered read data, rdValid pulses when it is updated
//   realLock,
//   imagLock      per-channel asynchronous lock inputs
//   Index         per-channel combiner index (read-only, LEAD[31:24])
//   updateStrobe  frame-boundary commit request for all pending channels
//   lagCoef .. refLevel  active coefficient outputs, channel c at slice c
//   commitDone    one-cycle pulse after any shadow-to-active copy
// ---------------------------------------------------------------------------
module combiner_regs_bank #(
    parameter int          NUM_CH          = 2,
    parameter int          CH_W            = 3,
    parameter logic [31:0] RESET_REF_LEVEL = 32'h0000_0000
) (
    input  logic                  busClk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic                  wr2,
    input  logic                  wr3,
    input  logic                  rd,
    input  logic [4+CH_W:0]       addr,
    input  logic [31:0]           dataIn,
    output logic [31:0]           dataOut,
    output logic                  rdValid,
    input  logic [NUM_CH-1:0]     realLock,
    input  logic [NUM_CH-1:0]     imagLock,
    input  logic [8*NUM_CH-1:0]   Index,
    input  logic                  updateStrobe,
    output logic [29*NUM_CH-1:0]  lagCoef,
    output logic [24*NUM_CH-1:0]  leadCoef,
    output logic [32*NUM_CH-1:0]  sweepRate,
    output logic [16*NUM_CH-1:0]  sweepLimit,
    output logic [16*NUM_CH-1:0]  options,
    output logic [32*NUM_CH-1:0]  refLevel,
    output logic                  commitDone
);

    localparam logic [2:0] W_LAG    = 3'd0;
    localparam logic [2:0] W_LEAD   = 3'd1;
    localparam logic [2:0] W_RATE   = 3'd2;
    localparam logic [2:0] W_LIMOPT = 3'd3;
    localparam logic [2:0] W_REF    = 3'd4;
    localparam logic [2:0] W_STATUS = 3'd5;

    logic [3:0]        be;
    logic [31:0]       byteMask;
    logic [CH_W-1:0]   chIdx;
    logic [2:0]        word;
    logic [NUM_CH-1:0] chSel;
    logic [NUM_CH-1:0] cfgWrite;
    logic [NUM_CH-1:0] statusClr;
    logic [31:0]       selRw;
    logic [31:0]       newWord;
    logic [31:0]       rdMux;

    // Bus-visible (writable) coefficient copies: shadow when double
    // buffering is built in, the live registers otherwise.
    logic [28:0] lagCfg  [NUM_CH];
    logic [23:0] leadCfg [NUM_CH];
    logic [31:0] rateCfg [NUM_CH];
    logic [15:0] limCfg  [NUM_CH];
    logic [15:0] optCfg  [NUM_CH];
    logic [31:0] refCfg  [NUM_CH];

    // Coefficients the datapaths actually use.
    logic [28:0] lagAct  [NUM_CH];
    logic [23:0] leadAct [NUM_CH];
    logic [31:0] rateAct [NUM_CH];
    logic [15:0] limAct  [NUM_CH];
    logic [15:0] optAct  [NUM_CH];
    logic [31:0] refAct  [NUM_CH];

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] realS1, realS2, realPrev, realLost;
    logic [NUM_CH-1:0] imagS1, imagS2, imagPrev, imagLost;
    logic              addrUnused;

    assign be       = cs ? {wr3, wr2, wr1, wr0} : 4'b0000;
    assign byteMask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign chIdx    = addr[4+CH_W:5];
    assign word     = addr[4:2];

    // One-hot channel decode; an out-of-range channel index selects nothing,
    // which makes both its reads (0) and its writes (ignored) fall out.
    always_comb begin
        chSel     = '0;
        cfgWrite  = '0;
        statusClr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chSel[c]     = (chIdx == CH_W'(c));
            cfgWrite[c]  = chSel[c] && (|be) && (word <= W_REF);
            statusClr[c] = chSel[c] && cs && rd && (word == W_STATUS);
        end
    end

    // Read mux and the writable view of the addressed word. The writable
    // view is merged with the byte-enabled write data so each field register
    // can just take its slice of newWord; read-only bits are never stored.
    always_comb begin
        selRw = '0;
        rdMux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (chSel[c]) begin
                case (word)
                    W_LAG: begin
                        selRw = {3'b000, lagCfg[c]};
                        rdMux = {realS2[c] | imagS2[c], realS2[c], imagS2[c], lagCfg[c]};
                    end
                    W_LEAD: begin
                        selRw = {8'h00, leadCfg[c]};
                        rdMux = {Index[8*c +: 8], leadCfg[c]};
                    end
                    W_RATE: begin
                        selRw = rateCfg[c];
                        rdMux = rateCfg[c];
                    end
                    W_LIMOPT: begin
                        selRw = {optCfg[c], limCfg[c]};
                        rdMux = {optCfg[c], limCfg[c]};
                    end
                    W_REF: begin
                        selRw = refCfg[c];
                        rdMux = refCfg[c];
                    end
                    W_STATUS: begin
                        rdMux = {29'd0, pending[c], imagLost[c], realLost[c]};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign newWord = (selRw & ~byteMask) | (dataIn & byteMask);

    // Writable coefficient registers. The REF_LEVEL copy resets to
    // RESET_REF_LEVEL so that a later commit of an unrelated word does not
    // clobber the reset reference level.
    always_ff @(posedge busClk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lagCfg[c]  <= '0;
                leadCfg[c] <= '0;
                rateCfg[c] <= '0;
                limCfg[c]  <= '0;
                optCfg[c]  <= '0;
                refCfg[c]  <= RESET_REF_LEVEL;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfgWrite[c]) begin
                    case (word)
                        W_LAG:    lagCfg[c]  <= newWord[28:0];
                        W_LEAD:   leadCfg[c] <= newWord[23:0];
                        W_RATE:   rateCfg[c] <= newWord;
                        W_LIMOPT: begin
                            limCfg[c] <= newWord[15:0];
                            optCfg[c] <= newWord[31:16];
                        end
                        W_REF:    refCfg[c]  <= newWord;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef COMB_SHADOW_EN
    localparam logic [2:0] W_COMMIT = 3'd6;

    logic [NUM_CH-1:0] commitReq;
    logic [NUM_CH-1:0] copyCh;

    // Commit targets: the strobe hits every channel, COMMIT bit0 only the
    // addressed one, COMMIT bit1 all of them (only via a valid channel).
    always_comb begin
        commitReq = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            commitReq[c] = updateStrobe ||
                           (be[0] && (word == W_COMMIT) &&
                            ((chSel[c] && dataIn[0]) || ((|chSel) && dataIn[1])));
        end
    end

    assign copyCh = commitReq & pending;

    // Shadow-to-active copy. Active samples the shadow before this edge's
    // write, and a same-edge config write keeps the channel pending.
    always_ff @(posedge busClk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lagAct[c]  <= '0;
                leadAct[c] <= '0;
                rateAct[c] <= '0;
                limAct[c]  <= '0;
                optAct[c]  <= '0;
                refAct[c]  <= RESET_REF_LEVEL;
            end
            pending    <= '0;
            commitDone <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (copyCh[c]) begin
                    lagAct[c]  <= lagCfg[c];
                    leadAct[c] <= leadCfg[c];
                    rateAct[c] <= rateCfg[c];
                    limAct[c]  <= limCfg[c];
                    optAct[c]  <= optCfg[c];
                    refAct[c]  <= refCfg[c];
                end
            end
            pending    <= (pending & ~copyCh) | cfgWrite;
            commitDone <= |copyCh;
        end
    end

    assign addrUnused = ^addr[1:0];
`else
    // Without double buffering the bus registers drive the datapaths.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            lagAct[c]  = lagCfg[c];
            leadAct[c] = leadCfg[c];
            rateAct[c] = rateCfg[c];
            limAct[c]  = limCfg[c];
            optAct[c]  = optCfg[c];
            refAct[c]  = refCfg[c];
        end
    end

    assign pending    = '0;
    assign commitDone = 1'b0;
    assign addrUnused = ^{addr[1:0], updateStrobe};
`endif

    // Flatten the per-channel active registers onto the output buses.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            lagCoef[29*c +: 29]    = lagAct[c];
            leadCoef[24*c +: 24]   = leadAct[c];
            sweepRate[32*c +: 32]  = rateAct[c];
            sweepLimit[16*c +: 16] = limAct[c];
            options[16*c +: 16]    = optAct[c];
            refLevel[32*c +: 32]   = refAct[c];
        end
    end

    // Lock synchronisers plus one extra stage to detect a falling synced
    // lock. A loss in the same cycle as the clearing STATUS read wins.
    always_ff @(posedge busClk or posedge reset) begin
        if (reset) begin
            realS1   <= '0;
            realS2   <= '0;
            realPrev <= '0;
            realLost <= '0;
            imagS1   <= '0;
            imagS2   <= '0;
            imagPrev <= '0;
            imagLost <= '0;
        end else begin
            realS1   <= realLock;
            realS2   <= realS1;
            realPrev <= realS2;
            realLost <= (realPrev & ~realS2) | (realLost & ~statusClr);
            imagS1   <= imagLock;
            imagS2   <= imagS1;
            imagPrev <= imagS2;
            imagLost <= (imagPrev & ~imagS2) | (imagLost & ~statusClr);
        end
    end

    // Registered read port: dataOut holds between reads, rdValid marks the
    // cycle after a read strobe. A simultaneous write returns old data.
    always_ff @(posedge busClk or posedge reset) begin
        if (reset) begin
            dataOut <= '0;
            rdValid <= 1'b0;
        end else begin
            if (cs && rd) begin
                dataOut <= rdMux;
            end
            rdValid <= cs && rd;
        end
    end

endmodule
